// File: rtl/byte_bus_pkg.sv
// Shared slot map and rw-flag encoding for the 10-slot byte-serial CPU bus.
// Used by both the CPU handler and the memory-side responder.
package byte_bus_pkg;

    // Slot n is the n-th cycle after the sof cycle. The sof cycle itself is slot 0.
    typedef enum logic [3:0] {
        SLOT_SOF      = 4'd0,
        SLOT_A0       = 4'd1,
        SLOT_A1       = 4'd2,
        SLOT_A2       = 4'd3,
        SLOT_A3       = 4'd4,
        SLOT_RW       = 4'd5,
        SLOT_RD_FIRST = 4'd6,
        SLOT_RD1      = 4'd7,
        SLOT_RD2      = 4'd8,
        SLOT_LAST     = 4'd9,
        SLOT_IDLE     = 4'd15
    } slot_e;

    localparam int   FRAME_LEN = 10;
    localparam logic RW_WRITE  = 1'b1;
    localparam logic RW_READ   = 1'b0;

endpackage

// File: rtl/byte_bus_mem.sv
// Single-port word array: synchronous write, synchronous read.
// Locations not written since reset read back as INIT_WORD.
module byte_bus_mem #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] INIT_WORD = 32'h0000_0000,
    parameter int          IDX_W     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0]      mem [DEPTH];
    logic [DEPTH-1:0] written;

    // The word array has no reset; a per-word flag stands in for an init pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written <= '0;
        end else if (we) begin
            written[addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= written[addr] ? mem[addr] : INIT_WORD;
        end
    end

endmodule

// File: rtl/byte_bus_mem_responder.sv
// Memory-side responder for the 10-slot byte-serial CPU bus.
// Optional address range check: define BYTE_BUS_ADDR_CHECK_EN.
module byte_bus_mem_responder
    import byte_bus_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] INIT_WORD = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sof,
    input  logic [7:0] addr_in,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       frame_done,
    output logic       err
);

    localparam int IDX_W = $clog2(DEPTH);

    slot_e             slot_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [23:0]       rd_shift_q;
    logic [31:0]       addr_full;
    logic [31:0]       mem_rdata;
    logic [31:0]       rd_word;
    logic [IDX_W-1:0]  mem_idx;
    logic              mem_we;
    logic              mem_re;
    logic              in_range;
    logic              unused_addr_bits;

    // The memory read is launched during slot 4 with the last address byte
    // still on the lane, so the word is ready for the slot 5 edge.
    assign addr_full = {addr_in, addr_q[23:0]};
    assign mem_re    = (slot_q == SLOT_A3) && !sof;
    assign mem_idx   = (slot_q == SLOT_A3) ? addr_full[IDX_W+1:2] : addr_q[IDX_W+1:2];
    assign mem_we    = (slot_q == SLOT_RW) && !sof && (addr_in[0] == RW_WRITE) && in_range;
    assign rd_word   = in_range ? mem_rdata : 32'h0;

    assign unused_addr_bits = ^{addr_q[31:IDX_W+2], addr_q[1:0],
                                addr_full[31:IDX_W+2], addr_full[1:0]};

`ifdef BYTE_BUS_ADDR_CHECK_EN
    logic err_q;

    assign in_range = ((addr_q >> (IDX_W + 2)) == 32'd0) && (addr_q[1:0] == 2'b00);
    assign err      = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((slot_q == SLOT_RW) && !sof && !in_range) begin
            err_q <= 1'b1;
        end
    end
`else
    assign in_range = 1'b1;
    assign err      = 1'b0;
`endif

    byte_bus_mem #(
        .DEPTH     (DEPTH),
        .INIT_WORD (INIT_WORD),
        .IDX_W     (IDX_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_idx),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    // slot_q holds the number of the slot currently on the bus; the sof
    // cycle is slot 0, so the edge ending it moves straight to slot 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q     <= SLOT_IDLE;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rd_shift_q <= 24'h0;
            data_out   <= 8'h00;
            data_oe    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (slot_q == SLOT_LAST);
            if (sof) begin
                slot_q     <= SLOT_A0;
                data_out   <= 8'h00;
                data_oe    <= 1'b0;
                rd_shift_q <= 24'h0;
            end else begin
                case (slot_q)
                    SLOT_A0: begin
                        addr_q[7:0]  <= addr_in;
                        wdata_q[7:0] <= data_in;
                        slot_q       <= SLOT_A1;
                    end
                    SLOT_A1: begin
                        addr_q[15:8]  <= addr_in;
                        wdata_q[15:8] <= data_in;
                        slot_q        <= SLOT_A2;
                    end
                    SLOT_A2: begin
                        addr_q[23:16]  <= addr_in;
                        wdata_q[23:16] <= data_in;
                        slot_q         <= SLOT_A3;
                    end
                    SLOT_A3: begin
                        addr_q[31:24]  <= addr_in;
                        wdata_q[31:24] <= data_in;
                        slot_q         <= SLOT_RW;
                    end
                    SLOT_RW: begin
                        slot_q <= SLOT_RD_FIRST;
                        if (addr_in[0] == RW_WRITE) begin
                            data_oe  <= 1'b0;
                            data_out <= 8'h00;
                        end else begin
                            data_oe    <= 1'b1;
                            data_out   <= rd_word[7:0];
                            rd_shift_q <= rd_word[31:8];
                        end
                    end
                    SLOT_RD_FIRST, SLOT_RD1, SLOT_RD2: begin
                        slot_q <= slot_e'(slot_q + 4'd1);
                        if (data_oe) begin
                            data_out   <= rd_shift_q[7:0];
                            rd_shift_q <= {8'h00, rd_shift_q[23:8]};
                        end
                    end
                    SLOT_LAST: begin
                        slot_q   <= SLOT_IDLE;
                        data_out <= 8'h00;
                        data_oe  <= 1'b0;
                    end
                    default: begin
                        slot_q <= SLOT_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
